mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have ports: clk input 1 (clock); rst input 1 (reset, asynchronous, active-high).
REQ-002 SHALL have inputs from the EX/MEM register: mem_result 32 (byte address); mem_op2_selected 32 (store data); mem_memory_write 1; mem_memory_load_type 3; mem_memory_store_type 2; mem_wb_load 1.
REQ-003 SHALL drive stall (output, 1 bit), which freezes the PC, the pipeline registers and the EX/MEM register.
REQ-004 SHALL drive load_data (output, 32 bits), the formatted load result.
REQ-005 SHALL drive load_valid (output, 1 bit) and misaligned (output, 1 bit).
REQ-006 SHALL have data bus ports: dbus_req out 1; dbus_we out 1; dbus_addr out 32 (word-aligned, bits[1:0]=0); dbus_wdata out 32; dbus_be out 4; dbus_ack in 1; dbus_rdata in 32.

Function
REQ-007 SHALL use these load encodings: 000 LB, 001 LH, 010 LW, 011 LBU, 100 LHU, 111 none; 101 and 110 are treated as none.
REQ-008 SHALL use these store encodings: 00 none, 01 SB, 10 SH, 11 SW.
REQ-009 An access is pending in IDLE when either condition holds:
- store: mem_memory_write=1 and store_type!=00;
- load: mem_wb_load=1 and load_type is not none.
REQ-010 If both a store and a load are pending, the store SHALL win and the load is ignored.
REQ-011 SHALL implement a state machine with states IDLE, BUSY and DONE; reset state is IDLE.
REQ-012 In IDLE with an access pending, the block SHALL:
- assert stall combinationally in that cycle;
- register address, we, wdata and be;
- go to BUSY.
REQ-013 In BUSY, the block SHALL:
- hold dbus_req=1 with addr, we, wdata and be stable;
- hold stall=1;
- on dbus_ack=1, capture dbus_rdata (for loads), drop dbus_req and go to DONE.
REQ-014 dbus_ack SHALL be accepted in any BUSY cycle, including the first; dbus_ack outside BUSY SHALL be ignored.
REQ-015 In DONE (one cycle), the block SHALL drive stall=0 and load_valid=1 for loads (0 for stores), then go to IDLE unconditionally; inputs are not re-examined in DONE.
REQ-016 Minimum latency SHALL be: request in cycle N, dbus_req from N+1, ack at M>=N+1, DONE at M+1; 3 cycles for a zero-wait bus.
REQ-017 SHALL compute off=mem_result[1:0] and drive dbus_addr = {mem_result[31:2],2'b00}.
REQ-018 Store byte enables and data SHALL be:
- SB: be = 0001<<off, wdata = the byte replicated x4;
- SH: be = 0011<<off, wdata = the halfword replicated x2;
- SW: be = 1111, wdata = op2.
REQ-019 Load formatting SHALL take the byte at lane off (LB/LBU), the halfword at lane off (LH/LHU) or the full word (LW), with LB/LH sign-extended and LBU/LHU zero-extended to 32 bits.
REQ-020 load_data SHALL be registered and hold its last value until the next load completes.
REQ-021 With no access pending in IDLE, the block SHALL keep stall=0 and dbus_req=0 and stay in IDLE.

Reset
REQ-022 On rst, outputs SHALL immediately take these values: state=IDLE, dbus_req=0, dbus_we=0, dbus_addr=0, dbus_wdata=0, dbus_be=0000, load_data=0, load_valid=0, misaligned=0, stall=0.
REQ-023 A reset asserted mid-access (BUSY) SHALL abandon the transfer; a later dbus_ack is ignored.

Configuration
REQ-024 Macro MEM_MISALIGN_TRAP_EN defined: a misaligned access SHALL issue no bus request and go IDLE->DONE with misaligned=1 for one cycle and load_valid=0.
- Misaligned means LH/LHU/SH with off[0]=1, or LW/SW with off!=00.
REQ-025 Macro undefined: misaligned SHALL be tied 0, and the low address bits are ignored as follows:
- halfword accesses use off={mem_result[1],0};
- word accesses use off=00.

Verification
REQ-026 SW addr 0x100, data 0xDEADBEEF, ack on first BUSY cycle -> dbus_addr=0x100, be=1111, wdata=0xDEADBEEF, we=1; stall high 2 cycles; load_valid=0.
REQ-027 LB addr 0x203, rdata 0x80FF1234 -> load_data=0xFFFFFF80 with load_valid=1 in DONE; LBU same -> 0x00000080.
REQ-028 SH addr 0x302, data 0x0000ABCD, ack after 3 wait cycles -> be=1100, wdata=0xABCDABCD; req and addr stable until ack; stall deasserts the cycle after ack.
REQ-029 LW addr 0x401, both macro settings:
- with MEM_MISALIGN_TRAP_EN: no dbus_req, misaligned=1 for one cycle;
- without: dbus_addr=0x400 with a full word returned.
REQ-030 Reset asserted while in BUSY with dbus_req=1 -> dbus_req=0 and stall=0 immediately; an ack arriving after reset release causes no load_valid.

Source files
------------

// File: rtl/mem_access_unit.sv
// Data-bus access unit: IDLE->BUSY->DONE handshake, store lane steering, load formatting.
// Optional misaligned trap is built in when MEM_MISALIGN_TRAP_EN is defined.
module mem_access_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] mem_result,
   input  logic [31:0] mem_op2_selected,
   input  logic        mem_memory_write,
   input  logic [2:0]  mem_memory_load_type,
   input  logic [1:0]  mem_memory_store_type,
   input  logic        mem_wb_load,
   output logic        stall,
   output logic [31:0] load_data,
   output logic        load_valid,
   output logic        misaligned,
   output logic        dbus_req,
   output logic        dbus_we,
   output logic [31:0] dbus_addr,
   output logic [31:0] dbus_wdata,
   output logic [3:0]  dbus_be,
   input  logic        dbus_ack,
   input  logic [31:0] dbus_rdata
);

   localparam logic [2:0] LD_LB  = 3'b000;
   localparam logic [2:0] LD_LH  = 3'b001;
   localparam logic [2:0] LD_LW  = 3'b010;
   localparam logic [2:0] LD_LBU = 3'b011;
   localparam logic [2:0] LD_LHU = 3'b100;
   localparam logic [1:0] ST_SB  = 2'b01;
   localparam logic [1:0] ST_SH  = 2'b10;
   localparam logic [1:0] ST_SW  = 2'b11;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   state_t state;

   logic        is_store, is_load, pending, acc_half, acc_word, mis_acc;
   logic [1:0]  off, eff_off;
   logic [3:0]  st_be;
   logic [31:0] st_wdata;
   logic        ld_q;
   logic [2:0]  ld_type_q;
   logic [1:0]  ld_off_q;

   function automatic logic [31:0] fmt_load(input logic [2:0] t, input logic [1:0] o,
                                            input logic [31:0] d);
      logic [31:0] sh;
      sh = d >> {o, 3'b000};
      case (t)
         LD_LB:   return {{24{sh[7]}}, sh[7:0]};
         LD_LBU:  return {24'h0, sh[7:0]};
         LD_LH:   return {{16{sh[15]}}, sh[15:0]};
         LD_LHU:  return {16'h0, sh[15:0]};
         default: return d;
      endcase
   endfunction

   always_comb begin
      off      = mem_result[1:0];
      is_store = mem_memory_write && (mem_memory_store_type != 2'b00);
      is_load  = mem_wb_load && (mem_memory_load_type <= LD_LHU);
      pending  = is_store || is_load;
      // A pending store owns the cycle, so size is taken from the store type then.
      if (is_store) begin
         acc_half = (mem_memory_store_type == ST_SH);
         acc_word = (mem_memory_store_type == ST_SW);
      end else begin
         acc_half = (mem_memory_load_type == LD_LH) || (mem_memory_load_type == LD_LHU);
         acc_word = (mem_memory_load_type == LD_LW);
      end
      eff_off  = acc_word ? 2'b00 : (acc_half ? {off[1], 1'b0} : off);
      st_be    = 4'b1111;
      st_wdata = mem_op2_selected;
      case (mem_memory_store_type)
         ST_SB: begin
            st_be    = 4'b0001 << eff_off;
            st_wdata = {4{mem_op2_selected[7:0]}};
         end
         ST_SH: begin
            st_be    = 4'b0011 << eff_off;
            st_wdata = {2{mem_op2_selected[15:0]}};
         end
         default: ;
      endcase
`ifdef MEM_MISALIGN_TRAP_EN
      mis_acc = (acc_half && off[0]) || (acc_word && (off != 2'b00));
`else
      mis_acc = 1'b0;
`endif
   end

   assign stall = !rst && (((state == IDLE) && pending) || (state == BUSY));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         dbus_req   <= 1'b0;
         dbus_we    <= 1'b0;
         dbus_addr  <= 32'h0;
         dbus_wdata <= 32'h0;
         dbus_be    <= 4'b0000;
         load_data  <= 32'h0;
         load_valid <= 1'b0;
         ld_q       <= 1'b0;
         ld_type_q  <= 3'b000;
         ld_off_q   <= 2'b00;
      end else begin
         case (state)
            IDLE: begin
               if (pending) begin
                  if (mis_acc) begin
                     state <= DONE;
                  end else begin
                     state      <= BUSY;
                     dbus_req   <= 1'b1;
                     dbus_we    <= is_store;
                     dbus_addr  <= {mem_result[31:2], 2'b00};
                     dbus_wdata <= is_store ? st_wdata : 32'h0;
                     dbus_be    <= is_store ? st_be : 4'b1111;
                     ld_q       <= !is_store;
                     ld_type_q  <= mem_memory_load_type;
                     ld_off_q   <= eff_off;
                  end
               end
            end
            BUSY: begin
               if (dbus_ack) begin
                  dbus_req <= 1'b0;
                  state    <= DONE;
                  if (ld_q) begin
                     load_data  <= fmt_load(ld_type_q, ld_off_q, dbus_rdata);
                     load_valid <= 1'b1;
                  end
               end
            end
            default: begin
               // DONE lasts exactly one cycle; the EX/MEM inputs are not looked at here.
               state      <= IDLE;
               load_valid <= 1'b0;
            end
         endcase
      end
   end

`ifdef MEM_MISALIGN_TRAP_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         misaligned <= 1'b0;
      else
         misaligned <= (state == IDLE) && pending && mis_acc;
   end
`else
   assign misaligned = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a queue scoreboard of expected bus beats and load results.
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] mem_result, mem_op2_selected;
   logic        mem_memory_write, mem_wb_load;
   logic [2:0]  mem_memory_load_type;
   logic [1:0]  mem_memory_store_type;
   logic        stall, load_valid, misaligned;
   logic [31:0] load_data;
   logic        dbus_req, dbus_we, dbus_ack;
   logic [31:0] dbus_addr, dbus_wdata, dbus_rdata;
   logic [3:0]  dbus_be;

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
   } bus_t;

   bus_t        bus_q[$];
   logic [31:0] ld_q[$];
   int          total = 0;
   int          bad = 0;

   always #5 clk = ~clk;

   mem_access_unit dut (
      .clk(clk), .rst(rst),
      .mem_result(mem_result), .mem_op2_selected(mem_op2_selected),
      .mem_memory_write(mem_memory_write), .mem_memory_load_type(mem_memory_load_type),
      .mem_memory_store_type(mem_memory_store_type), .mem_wb_load(mem_wb_load),
      .stall(stall), .load_data(load_data), .load_valid(load_valid), .misaligned(misaligned),
      .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr), .dbus_wdata(dbus_wdata),
      .dbus_be(dbus_be), .dbus_ack(dbus_ack), .dbus_rdata(dbus_rdata)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_in();
      mem_result            = 32'h0;
      mem_op2_selected      = 32'h0;
      mem_memory_write      = 1'b0;
      mem_memory_store_type = 2'b00;
      mem_wb_load           = 1'b0;
      mem_memory_load_type  = 3'b111;
   endtask

   // One complete access: wr/stt describe the store side, ldf/ldt the load side.
   task automatic access(input logic wr, input logic [1:0] stt, input logic ldf,
                         input logic [2:0] ldt, input logic [31:0] addr, input logic [31:0] data,
                         input logic [31:0] rdata, input int waits);
      bus_t        e, got;
      logic [31:0] sh, exp_ld;
      logic [1:0]  o;
      bit          st_win;
      st_win  = wr && (stt != 2'b00);
      e.we    = st_win;
      e.addr  = {addr[31:2], 2'b00};
      e.be    = 4'hF;
      e.wdata = 32'h0;
      exp_ld  = 32'h0;
      if (st_win) begin
         case (stt)
            2'b01: begin e.be = 4'b0001 << addr[1:0]; e.wdata = {4{data[7:0]}}; end
            2'b10: begin o = {addr[1], 1'b0}; e.be = 4'b0011 << o; e.wdata = {2{data[15:0]}}; end
            default: e.wdata = data;
         endcase
      end else begin
         case (ldt)
            3'b000: begin sh = rdata >> (8 * addr[1:0]); exp_ld = {{24{sh[7]}}, sh[7:0]}; end
            3'b011: begin sh = rdata >> (8 * addr[1:0]); exp_ld = {24'h0, sh[7:0]}; end
            3'b001: begin sh = rdata >> (16 * addr[1]); exp_ld = {{16{sh[15]}}, sh[15:0]}; end
            3'b100: begin sh = rdata >> (16 * addr[1]); exp_ld = {16'h0, sh[15:0]}; end
            default: exp_ld = rdata;
         endcase
         ld_q.push_back(exp_ld);
      end
      bus_q.push_back(e);

      mem_result            = addr;
      mem_op2_selected      = data;
      mem_memory_write      = wr;
      mem_memory_store_type = stt;
      mem_wb_load           = ldf;
      mem_memory_load_type  = ldt;
      #1;
      chk("stall_request_cycle", 32'(stall), 32'd1);
      step();
      got = bus_q.pop_front();
      chk("req_busy", 32'(dbus_req), 32'd1);
      chk("we", 32'(dbus_we), 32'(got.we));
      chk("addr", dbus_addr, got.addr);
      chk("be", 32'(dbus_be), 32'(got.be));
      chk("wdata", dbus_wdata, got.wdata);
      for (int i = 0; i < waits; i++) begin
         chk("stall_wait", 32'(stall), 32'd1);
         step();
         chk("req_held", 32'(dbus_req), 32'd1);
         chk("addr_held", dbus_addr, got.addr);
      end
      dbus_rdata = rdata;
      dbus_ack   = 1'b1;
      step();
      dbus_ack   = 1'b0;
      dbus_rdata = $urandom;
      chk("stall_done", 32'(stall), 32'd0);
      chk("req_done", 32'(dbus_req), 32'd0);
      chk("load_valid_done", 32'(load_valid), 32'(!st_win));
      chk("misaligned_done", 32'(misaligned), 32'd0);
      if (!st_win) chk("load_data", load_data, ld_q.pop_front());
      clear_in();
      step();
      chk("load_valid_after", 32'(load_valid), 32'd0);
      if (!st_win) chk("load_data_hold", load_data, exp_ld);
   endtask

   initial begin
      rst        = 1'b1;
      dbus_ack   = 1'b0;
      dbus_rdata = 32'h0;
      clear_in();
      #12;
      chk("rst_stall", 32'(stall), 32'd0);
      chk("rst_req", 32'(dbus_req), 32'd0);
      chk("rst_we", 32'(dbus_we), 32'd0);
      chk("rst_addr", dbus_addr, 32'h0);
      chk("rst_wdata", dbus_wdata, 32'h0);
      chk("rst_be", 32'(dbus_be), 32'd0);
      chk("rst_load_data", load_data, 32'h0);
      chk("rst_load_valid", 32'(load_valid), 32'd0);
      chk("rst_misaligned", 32'(misaligned), 32'd0);
      step();
      rst = 1'b0;
      step();
      step();
      chk("idle_stall", 32'(stall), 32'd0);
      chk("idle_req", 32'(dbus_req), 32'd0);

      // Load type 101 is a no-op.
      mem_wb_load          = 1'b1;
      mem_memory_load_type = 3'b101;
      #1;
      chk("none_stall", 32'(stall), 32'd0);
      step();
      chk("none_req", 32'(dbus_req), 32'd0);
      clear_in();

      access(1'b1, 2'b11, 1'b0, 3'b111, 32'h100, 32'hDEADBEEF, 32'h0, 0);
      access(1'b0, 2'b00, 1'b1, 3'b000, 32'h203, 32'h0, 32'h80FF1234, 0);
      access(1'b0, 2'b00, 1'b1, 3'b011, 32'h203, 32'h0, 32'h80FF1234, 0);
      access(1'b1, 2'b10, 1'b0, 3'b111, 32'h302, 32'h0000ABCD, 32'h0, 3);
      access(1'b0, 2'b00, 1'b1, 3'b001, 32'h102, 32'h0, 32'h80017FFF, 1);
      access(1'b0, 2'b00, 1'b1, 3'b100, 32'h100, 32'h0, 32'h1234F00D, 0);
      access(1'b1, 2'b01, 1'b0, 3'b111, 32'h105, 32'h12345678, 32'h0, 2);
      // Store and load together: the store wins.
      access(1'b1, 2'b11, 1'b1, 3'b010, 32'h208, 32'h0BADF00D, 32'h11112222, 0);

`ifdef MEM_MISALIGN_TRAP_EN
      mem_wb_load          = 1'b1;
      mem_memory_load_type = 3'b010;
      mem_result           = 32'h401;
      #1;
      chk("trap_stall", 32'(stall), 32'd1);
      step();
      chk("trap_req", 32'(dbus_req), 32'd0);
      chk("trap_misaligned", 32'(misaligned), 32'd1);
      chk("trap_load_valid", 32'(load_valid), 32'd0);
      chk("trap_stall_done", 32'(stall), 32'd0);
      clear_in();
      step();
      chk("trap_misaligned_clr", 32'(misaligned), 32'd0);
      chk("trap_req_after", 32'(dbus_req), 32'd0);
`else
      access(1'b0, 2'b00, 1'b1, 3'b010, 32'h401, 32'h0, 32'hCAFEF00D, 1);
      access(1'b1, 2'b10, 1'b0, 3'b111, 32'h301, 32'h00005A5A, 32'h0, 0);
`endif

      // Reset in the middle of a transfer.
      mem_wb_load          = 1'b1;
      mem_memory_load_type = 3'b010;
      mem_result           = 32'h500;
      step();
      chk("mid_req", 32'(dbus_req), 32'd1);
      chk("mid_addr", dbus_addr, 32'h500);
      #2;
      rst = 1'b1;
      #1;
      chk("mid_rst_req", 32'(dbus_req), 32'd0);
      chk("mid_rst_stall", 32'(stall), 32'd0);
      clear_in();
      step();
      rst        = 1'b0;
      dbus_rdata = 32'h77778888;
      dbus_ack   = 1'b1;
      step();
      dbus_ack = 1'b0;
      chk("late_ack_valid", 32'(load_valid), 32'd0);
      step();
      chk("late_ack_valid2", 32'(load_valid), 32'd0);
      chk("late_ack_req", 32'(dbus_req), 32'd0);
      chk("late_ack_data", load_data, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
